shift_reg_unit: RTL

//   Multicycle shift register stage fed by the shift-register entry mux (operand

---
 rtl/shift_reg_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/shift_reg_unit.sv
// rtl/shift_reg_unit.sv - iterative 1-bit-per-clock shift register stage (LOAD/SLL/SRL/SRA/ROR)
module shift_reg_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         opr_q, opr_d;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        opr_d   = opr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_NOP: begin
                        end
                        OP_SLL, OP_SRL, OP_SRA, OP_ROR: begin
                            out_d   = in_data;
                            opr_d   = op;
                            cnt_d   = shamt;
                            state_d = (shamt == '0) ? S_DONE : S_SHIFT;
                        end
                        // LOAD and the reserved 11x codes both just capture the operand
                        default: begin
                            out_d   = in_data;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                case (opr_q)
                    OP_SLL:  out_d = {out_q[WIDTH-2:0], 1'b0};
                    OP_SRL:  out_d = {1'b0, out_q[WIDTH-1:1]};
                    OP_SRA:  out_d = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
                    OP_ROR:  out_d = {out_q[0], out_q[WIDTH-1:1]};
                    default: out_d = out_q;
                endcase
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            opr_q   <= OP_NOP;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            opr_q   <= opr_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign out  = out_q;

endmodule
